// File: rtl/ui_debounce_if.sv
// ============================================================================
// ui_debounce_if : pad inputs, debounced levels/strobes and change-event handshake
// Revision 1.0
// ============================================================================
`default_nettype none

interface ui_debounce_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic             chg_valid;
  logic [WIDTH-1:0] chg_data;
  logic             chg_ready;
  logic             overrun;

  modport master (
    input  din,
    input  chg_ready,
    output dout,
    output rise,
    output fall,
    output chg_valid,
    output chg_data,
    output overrun
  );

  modport slave (
    output din,
    output chg_ready,
    input  dout,
    input  rise,
    input  fall,
    input  chg_valid,
    input  chg_data,
    input  overrun
  );
endinterface

`default_nettype wire

// File: rtl/ui_debounce.sv
// ============================================================================
// ui_debounce : per-bit synchronizer + debouncer with one-shot change snapshots
// Revision 1.0
// ============================================================================
`default_nettype none

module ui_debounce #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic          clk,
  input  logic          rst,
  ui_debounce_if.master bus
);
  localparam int            CW        = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] C_CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] C_CNT_ONE = CW'(1);

  logic [WIDTH-1:0] r_dout;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;
  logic             r_chg_valid;
  logic [WIDTH-1:0] r_chg_data;
  logic             r_overrun;
  logic [WIDTH-1:0] w_toggle;
  logic [WIDTH-1:0] w_dout_next;
  logic             w_any_change;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_cnt;
    logic                   w_mismatch;

    assign w_mismatch  = r_sync[SYNC_STAGES-1] != r_dout[i];
    assign w_toggle[i] = w_mismatch && (r_cnt == C_CNT_MAX);

    always_ff @(posedge clk) begin
      if (rst) begin
        r_sync <= '0;
        r_cnt  <= '0;
      end else begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], bus.din[i]};
        // A matching cycle or an accepted toggle both restart the count
        if (!w_mismatch || w_toggle[i]) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + C_CNT_ONE;
        end
      end
    end
  end

  assign w_dout_next  = r_dout ^ w_toggle;
  assign w_any_change = |w_toggle;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout      <= '0;
      r_rise      <= '0;
      r_fall      <= '0;
      r_chg_valid <= 1'b0;
      r_chg_data  <= '0;
      r_overrun   <= 1'b0;
    end else begin
      r_dout <= w_dout_next;
      r_rise <= w_toggle & ~r_dout;
      r_fall <= w_toggle & r_dout;
      // The event comes from the toggle decision so it lands with dout
      if (w_any_change) begin
        r_chg_valid <= 1'b1;
        r_chg_data  <= w_dout_next;
        if (r_chg_valid && !bus.chg_ready) begin
          r_overrun <= 1'b1;
        end
      end else if (r_chg_valid && bus.chg_ready) begin
        r_chg_valid <= 1'b0;
      end
    end
  end

  assign bus.dout      = r_dout;
  assign bus.rise      = r_rise;
  assign bus.fall      = r_fall;
  assign bus.chg_valid = r_chg_valid;
  assign bus.chg_data  = r_chg_data;
  assign bus.overrun   = r_overrun;

endmodule

`default_nettype wire

// File: doc/ui_debounce.md
# ui_debounce

Input-conditioning stage between the raw `ui_in` pads and the user logic of the top-level wrapper. It synchronizes and debounces each input bit, drives a stable level word plus per-bit rise/fall strobes, and issues a change-event snapshot on a valid/ready handshake so downstream logic processes each settled input change exactly once.

## Interface

Parameters:
- `WIDTH`, 8, number of input bits conditioned.
- `SYNC_STAGES`, 2, flip-flop stages in each bit's synchronizer. Minimum is 2.
- `DEBOUNCE_CYCLES`, 50000, consecutive mismatch cycles required to accept a new level. Minimum is 1. The counter width is `$clog2(DEBOUNCE_CYCLES+1)`.

Ports:
- `clk`  in  1  single clock; one clock; reset is synchronous and active-high.
- `rst`  in  1  synchronous active-high reset.
- `din`  in  WIDTH  raw asynchronous inputs (pads).
- `dout`  out  WIDTH  debounced stable levels.
- `rise`  out  WIDTH  one-cycle pulse per bit when `dout` bit goes 0→1.
- `fall`  out  WIDTH  one-cycle pulse per bit when `dout` bit goes 1→0.
- `chg_valid`  out  1  change-event snapshot pending.
- `chg_data`  out  WIDTH  `dout` value captured at the most recent change.
- `chg_ready`  in  1  consumer accepts the snapshot.
- `overrun`  out  1  sticky flag: an unconsumed snapshot was overwritten.

## Operation

- **Reset:** while `rst`=1 at an edge, the following registers clear to 0:
  - all synchronizer stages, all counters
  - `dout`, `rise`, `fall`
  - `chg_valid`, `chg_data`, `overrun`
- **Synchronizer:** each bit has its own chain of `SYNC_STAGES` flops. `s[i]` is the last stage.
- **Debounce, per bit, evaluated each edge:**
  - If `s[i]` == `dout[i]`: the counter clears to 0.
  - If `s[i]` != `dout[i]` and the counter < `DEBOUNCE_CYCLES-1`: the counter increments.
  - If `s[i]` != `dout[i]` and the counter == `DEBOUNCE_CYCLES-1`:
    - `dout[i]` toggles and the counter clears to 0.
    - `rise[i]` or `fall[i]` is 1 for exactly the next cycle.
  - Any single matching cycle before the threshold restarts the count. Glitches shorter than `DEBOUNCE_CYCLES` synchronized cycles are fully rejected.
- **Change event:** computed from the update decision, not from a comparison of the registered `dout`. On the edge where any `dout` bit toggles:
  - `chg_data` loads the new `dout` value.
  - `chg_valid` is set to 1.
  - Several bits toggling on the same edge produce one event.
- **Handshake:** a transfer occurs on an edge where `chg_valid`=1 and `chg_ready`=1.
  - Transfer, no new change: `chg_valid` clears to 0.
  - Transfer and new change on the same edge: the new snapshot loads, `chg_valid` stays 1, `overrun` is unaffected.
  - `chg_valid`=1, `chg_ready`=0, new change: `chg_data` is overwritten, `chg_valid` stays 1, `overrun` sets to 1.
  - `chg_data` is stable while `chg_valid`=1 and no new change occurs.
  - `chg_ready` is ignored while `chg_valid`=0.
- **`overrun`:** cleared only by `rst`.
- **Reset mid-operation:** reset discards any partial count and any pending event. Inputs held high through reset are re-accepted as a normal 0→1 change after reset releases.

## Timing

- **Latency:** a `din` bit step, held stable, appears on `dout` exactly `SYNC_STAGES + DEBOUNCE_CYCLES` rising edges after the first edge that samples the new value.
- **Same-edge updates:** `rise`/`fall`, `chg_valid`, and `chg_data` update on the same edge as `dout`.
- **Registered outputs:** all outputs are registered; there is no combinational path from `din` or `chg_ready` to any output.
- **Throughput:** one snapshot per cycle is sustainable when `chg_ready` is held at 1.
- **Minimum spacing:** accepted changes of a single bit are at least `DEBOUNCE_CYCLES` cycles apart.

## Test plan

All scenarios use `WIDTH`=8, `SYNC_STAGES`=2, `DEBOUNCE_CYCLES`=4.

1. **Reset values:** hold `rst` for 3 cycles with `din`=0xFF → all outputs read 0 during reset. After release, `dout` reaches 0xFF 6 edges later, with one `chg_valid` pulse/hold and `chg_data`=0xFF.
2. **Single-bit step:** `chg_ready`=1, `din`=0x01 from edge 0 → `dout`=0x01 after edge 6. `rise`=0x01 for one cycle. `chg_valid` is high for one cycle with `chg_data`=0x01.
3. **Glitch rejection:** `din[3]` high for 3 cycles, low for 1, high for 3, then low → `dout` stays 0x00, and `rise`, `fall`, `chg_valid` never assert.
4. **Overrun:** `chg_ready`=0; step `din` to 0x01, then to 0x03 eight cycles later:
   - after the second change: `chg_data`=0x03, `chg_valid`=1, `overrun`=1;
   - raising `chg_ready` for one cycle clears `chg_valid`; `overrun` stays 1 until `rst`.
5. **Simultaneous transfer and change:** `chg_valid`=1 with `chg_data`=0x01. Assert `chg_ready` on the exact edge `dout` goes to 0x81 → `chg_valid` stays 1, `chg_data`=0x81, `overrun`=0.
6. **Reset mid-count, multi-bit falling change:**
   - Assert `rst` for 1 cycle when a bit's counter reaches 2 → no change emitted; full latency restarts after release.
   - Separately, start from `dout`=0xF0 and drop all four bits together → `fall`=0xF0 for one cycle and one event with `chg_data`=0x00.
